// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines, deframes
// 11-bit frames, and strobes either a received byte or a frame error.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TO_WIDTH       = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboard_data,
    output logic       keyboard_rdy,
    output logic       frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] flt_q, dly_q;
    logic                  fclk_q, fclk_d, fclk_prev_q;
    logic                  fall, bit_in;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            sr_q, sr_d;
    logic                  par_q, par_d;
    logic [TO_WIDTH-1:0]   to_q, to_d;
    logic [7:0]            kbd_q, kbd_d;
    logic                  rdy_q, rdy_d, err_q, err_d;

    // The filtered clock only moves on a unanimous window; mixed samples hold the old level.
    always_comb begin
        fclk_d = fclk_q;
        if (flt_q == '0)
            fclk_d = 1'b0;
        else if (flt_q == '1)
            fclk_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            flt_q       <= '1;
            dly_q       <= '1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            dat_sync_q  <= {dat_sync_q[0], ps2_data};
            flt_q       <= {flt_q[FILTER_LEN-2:0], clk_sync_q[1]};
            dly_q       <= {dly_q[FILTER_LEN-2:0], dat_sync_q[1]};
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
        end
    end

    assign fall   = fclk_prev_q & ~fclk_q;
    assign bit_in = dly_q[FILTER_LEN-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        par_d   = par_q;
        kbd_d   = kbd_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        if (state_q == S_IDLE || fall)
            to_d = '0;
        else
            to_d = to_q + TO_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (fall && !bit_in) begin
                    state_d = S_DATA;
                    cnt_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    sr_d  = {bit_in, sr_q[7:1]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7)
                        state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = bit_in;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    if (bit_in && (^{sr_q, par_q})) begin
                        kbd_d = sr_q;
                        rdy_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A falling edge in the same cycle takes priority over an expiring timeout.
        if (state_q != S_IDLE && !fall && to_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            to_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            to_q    <= '0;
            kbd_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            to_q    <= to_d;
            kbd_q   <= kbd_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign keyboard_data = kbd_q;
    assign keyboard_rdy  = rdy_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: stimulus pushes expected strobes, a monitor pops and compares.
module tb_ps2_rx;

    localparam int unsigned N  = 4;
    localparam int unsigned T  = 1500;
    localparam int unsigned TW = 11;
    localparam int unsigned H  = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kdata;
    logic       krdy, ferr;

    always #5 clk = ~clk;

    ps2_rx #(.FILTER_LEN(N), .TIMEOUT_CYCLES(T), .TO_WIDTH(TW)) dut (
        .clk(clk),
        .reset(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .keyboard_data(kdata),
        .keyboard_rdy(krdy),
        .frame_err(ferr)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    logic [7:0] prev_k = 8'h00;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        #1;
        checks++;
        if (krdy && ferr) begin
            errors++;
            $display("FAIL both_strobes: rdy and err high together at cycle %0d", cyc);
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe: no strobe by deadline, expected err=%0d data=%0h at cycle %0d (now %0d)",
                     exp_q[0].is_err, exp_q[0].data, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (krdy || ferr) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: rdy=%0b err=%0b data=%0h at cycle %0d, expected none",
                         krdy, ferr, kdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (ferr != e.is_err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe: got err=%0b at cycle %0d, expected err=%0b at cycle %0d",
                             ferr, cyc, e.is_err, e.cyc);
                end
                if (!e.is_err) model_data = e.data;
            end
        end
        if (krdy || ferr || kdata !== prev_k) begin
            checks++;
            if (kdata !== model_data) begin
                errors++;
                $display("FAIL keyboard_data: got %0h expected %0h at cycle %0d", kdata, model_data, cyc);
            end
        end
        prev_k = kdata;
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Frame bit i is the i-th bit on the wire: start, 8 data LSB first, odd parity, stop.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int unsigned nbits, input bit glitch,
                             input bit push, input bit is_err, input logic [7:0] d,
                             output int unsigned plast);
        plast = 0;
        for (int unsigned i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            cycles(10);
            ps2_clk = 1'b0;
            plast = cyc;
            if (push && i == nbits - 1)
                exp_q.push_back('{is_err, d, cyc + N + 4});
            cycles(H);
            ps2_clk = 1'b1;
            if (glitch && i + 1 < nbits) begin
                cycles(10);
                ps2_clk = 1'b0;
                cycles(N - 1);
                ps2_clk = 1'b1;
            end
            cycles(H - 20);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        int unsigned pl;
        send_bits(make_frame(b, bad_par, bad_stop), 11, glitch, 1'b1, bad_par || bad_stop, b, pl);
        cycles(2 * H);
    endtask

    initial begin
        int unsigned pl;
        logic [7:0]  b;
        bit          bp, bs, gl;

        cycles(5);
        check("reset_data", {24'h0, kdata}, 32'h0);
        check("reset_rdy", {31'h0, krdy}, 32'h0);
        check("reset_err", {31'h0, ferr}, 32'h0);
        rst_n = 1'b1;
        cycles(20);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        check("data_after_parity_err", {24'h0, kdata}, 32'h1C);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);

        send_bits(make_frame(8'h37, 1'b0, 1'b0), 5, 1'b0, 1'b0, 1'b0, 8'h00, pl);
        exp_q.push_back('{1'b1, 8'h00, pl + N + 4 + T});
        cycles(T + 100);
        check("data_after_timeout", {24'h0, kdata}, 32'h5A);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);

        send_bits(make_frame(8'hAA, 1'b0, 1'b0), 6, 1'b0, 1'b0, 1'b0, 8'h00, pl);
        cycles(10);
        model_data = 8'h00;
        rst_n = 1'b0;
        cycles(3);
        check("data_in_midframe_reset", {24'h0, kdata}, 32'h0);
        rst_n = 1'b1;
        cycles(50);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        cycles(H);
        ps2_clk  = 1'b1;
        cycles(2 * H);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            b  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 7) == 0);
            gl = ($urandom_range(0, 1) == 1);
            send_frame(b, bp, bs, gl);
            cycles($urandom_range(0, 2 * H));
        end

        for (int unsigned i = 0; i < T + 200 && exp_q.size() > 0; i++)
            @(negedge clk);
        cycles(2);
        check("pending_expected", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
